// File: rtl/sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sched_pkg
// Brief   : State encoding and DMA channel codes for the tile scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
package sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LDK  = 3'd1,
      ST_LDX  = 3'd2,
      ST_LDI  = 3'd3,
      ST_CONV = 3'd4,
      ST_IFFT = 3'd5,
      ST_DONE = 3'd6
   } state_t;

   localparam logic [1:0] CH_IN   = 2'd0;
   localparam logic [1:0] CH_KRNL = 2'd1;
   localparam logic [1:0] CH_INDX = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dma_req_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dma_req_if
// Brief   : Single-outstanding DMA read request register with valid/ready
// Revision: 1.0
// ---------------------------------------------------------------------------
module dma_req_if #(
   parameter int ADDRLEN = 32,
   parameter int LENW    = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               i_issue,
   input  logic [ADDRLEN-1:0] i_addr,
   input  logic [LENW-1:0]    i_len,
   input  logic [1:0]         i_ch,
   input  logic               i_rdready,
   input  logic               i_rddone,
   output logic               o_rdvalid,
   output logic [ADDRLEN-1:0] o_rdaddr,
   output logic [LENW-1:0]    o_rdlen,
   output logic [1:0]         o_rdch,
   output logic               o_busy,
   output logic               o_done
);

   logic               r_valid;
   logic               r_pend;
   logic [ADDRLEN-1:0] r_addr;
   logic [LENW-1:0]    r_len;
   logic [1:0]         r_ch;

   // A completion only counts once the request has actually been accepted.
   assign o_done    = i_rddone && r_pend && !r_valid;
   assign o_busy    = r_pend;
   assign o_rdvalid = r_valid;
   assign o_rdaddr  = r_addr;
   assign o_rdlen   = r_len;
   assign o_rdch    = r_ch;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_valid <= 1'b0;
         r_pend  <= 1'b0;
         r_addr  <= '0;
         r_len   <= '0;
         r_ch    <= '0;
      end else if (i_issue && !r_pend) begin
         r_valid <= 1'b1;
         r_pend  <= 1'b1;
         r_addr  <= i_addr;
         r_len   <= i_len;
         r_ch    <= i_ch;
      end else begin
         if (r_valid && i_rdready) begin
            r_valid <= 1'b0;
         end
         if (o_done) begin
            r_pend <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/tile_sched_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tile_sched_ctrl
// Brief   : Layer sequencer: kernel/index/input DMA, conv and IFFT per tile
// Revision: 1.0
// ---------------------------------------------------------------------------
module tile_sched_ctrl
   import sched_pkg::*;
#(
   parameter int ADDRLEN = 32,
   parameter int CNTW    = 12,
   parameter int LENW    = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start,
   input  logic [CNTW-1:0]    numP,
   input  logic [CNTW-1:0]    numN,
   input  logic [ADDRLEN-1:0] addrin,
   input  logic [ADDRLEN-1:0] addrkrnl,
   input  logic [ADDRLEN-1:0] addrindx,
   input  logic [LENW-1:0]    inlen,
   input  logic [LENW-1:0]    krnllen,
   input  logic [LENW-1:0]    indxlen,
   output logic               rdvalid,
   input  logic               rdready,
   output logic [ADDRLEN-1:0] rdaddr,
   output logic [LENW-1:0]    rdlen,
   output logic [1:0]         rdch,
   input  logic               rddone,
   output logic               convstart,
   output logic               convbuf,
   input  logic               readynext,
   output logic               ifftstart,
   input  logic               ifftdone,
   output logic               layrdone,
   output logic [CNTW-1:0]    Pdone,
   output logic [CNTW-1:0]    Ndone
);

   localparam int              c_pad   = ADDRLEN - LENW;
   localparam logic [CNTW:0]   c_one_w = {{CNTW{1'b0}}, 1'b1};
   localparam logic [CNTW-1:0] c_one_c = {{(CNTW-1){1'b0}}, 1'b1};

   state_t             r_state;
   logic [CNTW-1:0]    r_nump, r_numn, r_p, r_n, r_pdone, r_ndone;
   logic [ADDRLEN-1:0] r_base_in, r_addr_in, r_addr_krnl, r_addr_indx;
   logic [LENW-1:0]    r_inlen, r_krnllen, r_indxlen;
   logic               r_req_sent, r_pf_issued, r_ifft_seen;
   logic               r_convstart, r_convbuf, r_ifftstart, r_layrdone;

   logic               w_issue, w_busy, w_done, w_more_p, w_more_n, w_pf_ok, w_ifft_ok;
   logic [CNTW:0]      w_p_inc, w_n_inc;
   logic [ADDRLEN-1:0] w_addr;
   logic [LENW-1:0]    w_len;
   logic [1:0]         w_ch;

   assign w_p_inc   = {1'b0, r_p} + c_one_w;
   assign w_n_inc   = {1'b0, r_n} + c_one_w;
   assign w_more_p  = w_p_inc < {1'b0, r_nump};
   assign w_more_n  = w_n_inc < {1'b0, r_numn};
   assign w_ifft_ok = ifftdone || r_ifft_seen;
   // With another tile to go, the tile may only retire once its prefetch has landed.
   assign w_pf_ok   = !w_more_p || (r_pf_issued && (!w_busy || w_done));

   always_comb begin
      w_issue = 1'b0;
      w_addr  = r_addr_in;
      w_len   = r_inlen;
      w_ch    = CH_IN;
      case (r_state)
         ST_LDK: begin
            w_issue = !r_req_sent && !w_busy;
            w_addr  = r_addr_krnl;
            w_len   = r_krnllen;
            w_ch    = CH_KRNL;
         end
         ST_LDX: begin
            w_issue = !r_req_sent && !w_busy;
            w_addr  = r_addr_indx;
            w_len   = r_indxlen;
            w_ch    = CH_INDX;
         end
         ST_LDI:           w_issue = !r_req_sent && !w_busy;
         ST_CONV, ST_IFFT: w_issue = w_more_p && !r_pf_issued && !w_busy;
         default:          w_issue = 1'b0;
      endcase
   end

   dma_req_if #(
      .ADDRLEN (ADDRLEN),
      .LENW    (LENW)
   ) u_dma_req_if (
      .clk       (clk),
      .rstn      (rstn),
      .i_issue   (w_issue),
      .i_addr    (w_addr),
      .i_len     (w_len),
      .i_ch      (w_ch),
      .i_rdready (rdready),
      .i_rddone  (rddone),
      .o_rdvalid (rdvalid),
      .o_rdaddr  (rdaddr),
      .o_rdlen   (rdlen),
      .o_rdch    (rdch),
      .o_busy    (w_busy),
      .o_done    (w_done)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= ST_IDLE;
         r_nump      <= '0;
         r_numn      <= '0;
         r_p         <= '0;
         r_n         <= '0;
         r_pdone     <= '0;
         r_ndone     <= '0;
         r_base_in   <= '0;
         r_addr_in   <= '0;
         r_addr_krnl <= '0;
         r_addr_indx <= '0;
         r_inlen     <= '0;
         r_krnllen   <= '0;
         r_indxlen   <= '0;
         r_req_sent  <= 1'b0;
         r_pf_issued <= 1'b0;
         r_ifft_seen <= 1'b0;
         r_convstart <= 1'b0;
         r_convbuf   <= 1'b0;
         r_ifftstart <= 1'b0;
         r_layrdone  <= 1'b0;
      end else begin
         r_convstart <= 1'b0;
         r_ifftstart <= 1'b0;
         // Each address pointer advances by one transfer length as its request issues.
         if (w_issue) begin
            if (r_state == ST_LDK) begin
               r_addr_krnl <= r_addr_krnl + {{c_pad{1'b0}}, r_krnllen};
            end else if (r_state == ST_LDX) begin
               r_addr_indx <= r_addr_indx + {{c_pad{1'b0}}, r_indxlen};
            end else begin
               r_addr_in <= r_addr_in + {{c_pad{1'b0}}, r_inlen};
            end
            if (r_state == ST_CONV || r_state == ST_IFFT) begin
               r_pf_issued <= 1'b1;
            end else begin
               r_req_sent <= 1'b1;
            end
         end
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (r_state == ST_DONE) begin
                  r_layrdone <= 1'b1;
               end
               if (start) begin
                  r_nump      <= numP;
                  r_numn      <= numN;
                  r_base_in   <= addrin;
                  r_addr_in   <= addrin;
                  r_addr_krnl <= addrkrnl;
                  r_addr_indx <= addrindx;
                  r_inlen     <= inlen;
                  r_krnllen   <= krnllen;
                  r_indxlen   <= indxlen;
                  r_p         <= '0;
                  r_n         <= '0;
                  r_pdone     <= '0;
                  r_ndone     <= '0;
                  r_convbuf   <= 1'b0;
                  r_req_sent  <= 1'b0;
                  r_pf_issued <= 1'b0;
                  r_ifft_seen <= 1'b0;
                  r_layrdone  <= 1'b0;
                  r_state     <= (numP == '0 || numN == '0) ? ST_DONE : ST_LDK;
               end
            end
            ST_LDK: begin
               if (w_done) begin
                  r_req_sent <= 1'b0;
                  r_state    <= ST_LDX;
               end
            end
            ST_LDX: begin
               if (w_done) begin
                  r_req_sent <= 1'b0;
                  r_state    <= ST_LDI;
               end
            end
            ST_LDI: begin
               if (w_done) begin
                  r_pf_issued <= 1'b0;
                  r_ifft_seen <= 1'b0;
                  r_convstart <= 1'b1;
                  r_state     <= ST_CONV;
               end
            end
            ST_CONV: begin
               if (readynext) begin
                  r_ifftstart <= 1'b1;
                  r_state     <= ST_IFFT;
               end
            end
            ST_IFFT: begin
               if (ifftdone && !r_ifft_seen) begin
                  r_pdone     <= r_pdone + c_one_c;
                  r_ifft_seen <= 1'b1;
               end
               if (w_ifft_ok && w_pf_ok) begin
                  r_ifft_seen <= 1'b0;
                  r_pf_issued <= 1'b0;
                  if (w_more_p) begin
                     r_p         <= w_p_inc[CNTW-1:0];
                     r_convbuf   <= ~r_convbuf;
                     r_convstart <= 1'b1;
                     r_state     <= ST_CONV;
                  end else begin
                     r_ndone <= r_ndone + c_one_c;
                     if (w_more_n) begin
                        r_p        <= '0;
                        r_n        <= w_n_inc[CNTW-1:0];
                        r_convbuf  <= 1'b0;
                        r_addr_in  <= r_base_in;
                        r_req_sent <= 1'b0;
                        r_state    <= ST_LDK;
                     end else begin
                        r_state <= ST_DONE;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign convstart = r_convstart;
   assign convbuf   = r_convbuf;
   assign ifftstart = r_ifftstart;
   assign layrdone  = r_layrdone;
   assign Pdone     = r_pdone;
   assign Ndone     = r_ndone;

endmodule
`default_nettype wire
